// File: rtl/md_issue_ctrl_if.sv
// Signal bundle between the E-stage pipeline, the MD unit and md_issue_ctrl.
`default_nettype none

interface md_issue_ctrl_if #(
    parameter int W = 32
);
  logic         e_valid;
  logic         flush;
  logic [3:0]   e_md_cls;
  logic [3:0]   d_md_cls;
  logic [W-1:0] e_rs;
  logic [W-1:0] e_rt;
  logic         md_busy;
  logic [W-1:0] md_hi;
  logic [W-1:0] md_lo;
  logic         md_start;
  logic [2:0]   md_op;
  logic [W-1:0] md_a;
  logic [W-1:0] md_b;
  logic [W-1:0] md_rdata;
  logic         stall_d;
  logic         md_err;

  modport master (
    output e_valid, flush, e_md_cls, d_md_cls, e_rs, e_rt, md_busy, md_hi, md_lo,
    input  md_start, md_op, md_a, md_b, md_rdata, stall_d, md_err
  );

  modport slave (
    input  e_valid, flush, e_md_cls, d_md_cls, e_rs, e_rt, md_busy, md_hi, md_lo,
    output md_start, md_op, md_a, md_b, md_rdata, stall_d, md_err
  );
endinterface

`default_nettype wire

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: issues ops, shadows the
// unit's latency, stalls D on MD hazards and flags Busy/shadow disagreement.
`default_nettype none

module md_issue_ctrl #(
    parameter int W       = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_issue_ctrl_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  logic          ok_e;
  logic          arith_e;
  logic          mt_e;
  logic          is_div_e;
  logic          issue;
  logic          illegal;
  logic          shadow;
  logic [2:0]    op_d;
  logic [W-1:0]  rdata_d;

  always_comb begin
    ok_e     = bus.e_valid & ~bus.flush;
    arith_e  = (bus.e_md_cls >= 4'd1) && (bus.e_md_cls <= 4'd5);
    mt_e     = (bus.e_md_cls == 4'd6) || (bus.e_md_cls == 4'd7);
    is_div_e = (bus.e_md_cls == 4'd3) || (bus.e_md_cls == 4'd4);
    shadow   = (cnt_q != '0);
    issue    = ok_e & arith_e & (state_q == IDLE);
    illegal  = ok_e & arith_e & (state_q != IDLE);

    op_d = 3'b111;
    if (issue) begin
      case (bus.e_md_cls)
        4'd1:    op_d = 3'b001;
        4'd2:    op_d = 3'b000;
        4'd3:    op_d = 3'b011;
        4'd4:    op_d = 3'b010;
        4'd5:    op_d = 3'b110;
        default: op_d = 3'b111;
      endcase
    end else if (ok_e & mt_e) begin
      op_d = (bus.e_md_cls == 4'd6) ? 3'b100 : 3'b101;
    end

    rdata_d = '0;
    if (ok_e && bus.e_md_cls == 4'd8) rdata_d = bus.md_hi;
    else if (ok_e && bus.e_md_cls == 4'd9) rdata_d = bus.md_lo;
  end

  assign bus.md_start = issue;
  assign bus.md_op    = op_d;
  assign bus.md_a     = bus.e_rs;
  assign bus.md_b     = bus.e_rt;
  assign bus.md_rdata = rdata_d;
  assign bus.stall_d  = (bus.d_md_cls != 4'd0) & (issue | shadow);
  assign bus.md_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // cnt_q is the unit's expected Busy; any disagreement is latched forever
      if ((bus.md_busy != shadow) || illegal) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q <= is_div_e ? DIV_WAIT : MUL_WAIT;
            cnt_q   <= is_div_e ? CW'(DIV_LAT) : CW'(MUL_LAT);
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          if (cnt_q <= CW'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a behavioural MD unit and controller model.
`default_nettype none

module tb_md_issue_ctrl;
  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  md_issue_ctrl_if #(.W(W)) bus ();

  md_issue_ctrl #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // controller model: the shadow is "cycle index lies within the busy window"
  int busy_end = -1;
  bit m_err    = 1'b0;
  bit chk_en   = 1'b0;

  // MD unit model driven by the bench
  int          u_rem     = 0;
  logic [31:0] u_hi      = '0;
  logic [31:0] u_lo      = '0;
  bit          force_low = 1'b0;
  logic        p_start;
  logic [2:0]  p_op;
  logic [31:0] p_a, p_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit          ok, arith, mt, shadow, e_start, e_stall;
    logic [2:0]  e_op;
    logic [31:0] e_rdata;
    p_start = bus.md_start && !reset;
    p_op    = bus.md_op;
    p_a     = bus.md_a;
    p_b     = bus.md_b;
    if (reset) begin
      busy_end = -1;
      m_err    = 1'b0;
    end else if (chk_en) begin
      ok      = bus.e_valid && !bus.flush;
      arith   = bus.e_md_cls inside {[4'd1:4'd5]};
      mt      = bus.e_md_cls inside {4'd6, 4'd7};
      shadow  = (cyc <= busy_end);
      e_start = ok && arith && !shadow;
      e_op    = 3'b111;
      if (e_start) begin
        case (bus.e_md_cls)
          4'd1: e_op = 3'b001;
          4'd2: e_op = 3'b000;
          4'd3: e_op = 3'b011;
          4'd4: e_op = 3'b010;
          default: e_op = 3'b110;
        endcase
      end else if (ok && mt) begin
        e_op = (bus.e_md_cls == 4'd6) ? 3'b100 : 3'b101;
      end
      e_rdata = '0;
      if (ok && bus.e_md_cls == 4'd8) e_rdata = bus.md_hi;
      if (ok && bus.e_md_cls == 4'd9) e_rdata = bus.md_lo;
      e_stall = (bus.d_md_cls != 4'd0) && (e_start || shadow);
      chk("start", bus.md_start, e_start);
      chk("op", bus.md_op, e_op);
      chk("a", bus.md_a, bus.e_rs);
      chk("b", bus.md_b, bus.e_rt);
      chk("rdata", bus.md_rdata, e_rdata);
      chk("stall", bus.stall_d, e_stall);
      chk("err", bus.md_err, m_err);
      if (e_start)
        busy_end = cyc + ((bus.e_md_cls inside {4'd3, 4'd4}) ? DIV_LAT : MUL_LAT);
      if ((bus.md_busy !== shadow) || (ok && arith && shadow)) m_err = 1'b1;
    end
  end

  task automatic drive_unit();
    bus.md_busy = (u_rem > 0) && !force_low;
    bus.md_hi   = u_hi;
    bus.md_lo   = u_lo;
  endtask

  task automatic unit_update();
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    sa = {{32{p_a[31]}}, p_a};
    sb = {{32{p_b[31]}}, p_b};
    qa = p_a;
    qb = p_b;
    if (u_rem > 0) u_rem--;
    if (p_start) begin
      u_rem = (p_op inside {3'b010, 3'b011}) ? DIV_LAT : MUL_LAT;
      case (p_op)
        3'b001: {u_hi, u_lo} = sa * sb;
        3'b000: {u_hi, u_lo} = {32'd0, p_a} * {32'd0, p_b};
        3'b110: {u_hi, u_lo} = {u_hi, u_lo} + sa * sb;
        3'b011: if (p_b != 0) begin u_lo = qa / qb; u_hi = qa % qb; end
        3'b010: if (p_b != 0) begin u_lo = p_a / p_b; u_hi = p_a % p_b; end
        default: ;
      endcase
    end else if (p_op == 3'b100) begin
      u_hi = p_a;
    end else if (p_op == 3'b101) begin
      u_lo = p_a;
    end
  endtask

  task automatic step(input bit v, input bit f, input logic [3:0] ec, input logic [3:0] dc,
                      input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    if (!reset) unit_update();
    drive_unit();
    bus.e_valid  = v;
    bus.flush    = f;
    bus.e_md_cls = ec;
    bus.d_md_cls = dc;
    bus.e_rs     = rs;
    bus.e_rt     = rt;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic count_stall(input logic [3:0] dc, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, dc, 0, 0);
      if (bus.stall_d) n++;
      else break;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    u_rem = 0;
    force_low = 1'b0;
    drive_unit();
    #1;
    chk("async_stall_clear", bus.stall_d, 1'b0);
    chk("async_err_clear", bus.md_err, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.e_valid = 0; bus.flush = 0; bus.e_md_cls = 0; bus.d_md_cls = 0;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bus.e_valid = 0; bus.flush = 0; bus.e_md_cls = 0; bus.d_md_cls = 4'd1;
    bus.e_rs = 0; bus.e_rt = 0;
    drive_unit();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start", bus.md_start, 1'b0);
    chk("rst_op", bus.md_op, 3'b111);
    chk("rst_rdata", bus.md_rdata, 32'd0);
    chk("rst_stall", bus.stall_d, 1'b0);
    chk("rst_err", bus.md_err, 1'b0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // mult 3 * -2 with mfhi waiting in D
    step(1, 0, 4'd1, 4'd8, 32'd3, 32'hFFFF_FFFE);
    chk("mult_start", bus.md_start, 1'b1);
    chk("mult_op", bus.md_op, 3'b001);
    count_stall(4'd8, n);
    chk("mult_stall_cycles", n, 5);
    step(1, 0, 4'd8, 4'd9, 0, 0);
    chk("mult_hi", bus.md_rdata, 32'hFFFF_FFFF);
    step(1, 0, 4'd9, 4'd0, 0, 0);
    chk("mult_lo", bus.md_rdata, 32'hFFFF_FFFA);

    // divu 7 / 2 with mflo waiting in D
    step(1, 0, 4'd4, 4'd9, 32'd7, 32'd2);
    chk("divu_op", bus.md_op, 3'b010);
    count_stall(4'd9, n);
    chk("divu_stall_cycles", n, 10);
    step(1, 0, 4'd9, 4'd8, 0, 0);
    chk("divu_lo", bus.md_rdata, 32'd3);
    step(1, 0, 4'd8, 4'd0, 0, 0);
    chk("divu_hi", bus.md_rdata, 32'd1);

    // flushed mult: nothing issues, nothing stalls
    step(1, 1, 4'd1, 4'd8, 32'd5, 32'd6);
    chk("flush_start", bus.md_start, 1'b0);
    chk("flush_op", bus.md_op, 3'b111);
    step(0, 0, 4'd0, 4'd8, 0, 0);
    chk("flush_no_stall", bus.stall_d, 1'b0);

    // mthi then mfhi
    step(1, 0, 4'd6, 4'd8, 32'h1234, 0);
    chk("mthi_op", bus.md_op, 3'b100);
    chk("mthi_start", bus.md_start, 1'b0);
    step(1, 0, 4'd8, 4'd0, 0, 0);
    chk("mthi_readback", bus.md_rdata, 32'h1234);
    chk("mthi_no_stall", bus.stall_d, 1'b0);

    // signed div, then mult + madd accumulation
    step(1, 0, 4'd3, 4'd0, 32'hFFFF_FFF9, 32'd2);
    idle(DIV_LAT);
    step(1, 0, 4'd9, 4'd0, 0, 0);
    chk("div_lo", bus.md_rdata, 32'hFFFF_FFFD);
    step(1, 0, 4'd8, 4'd0, 0, 0);
    chk("div_hi", bus.md_rdata, 32'hFFFF_FFFF);
    step(1, 0, 4'd1, 4'd0, 32'd2, 32'd3);
    idle(MUL_LAT);
    step(1, 0, 4'd5, 4'd0, 32'd4, 32'd5);
    chk("madd_op", bus.md_op, 3'b110);
    idle(MUL_LAT);
    step(1, 0, 4'd9, 4'd0, 0, 0);
    chk("madd_lo", bus.md_rdata, 32'h1A);

    // issue mult, then flushed mfhi in E while busy, then an illegal second arith
    step(1, 0, 4'd2, 4'd0, 32'hFFFF_FFFF, 32'd2);
    step(1, 1, 4'd8, 4'd8, 0, 0);
    step(1, 0, 4'd1, 4'd0, 32'd1, 32'd1);
    chk("illegal_no_start", bus.md_start, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    chk("illegal_err", bus.md_err, 1'b1);
    idle(MUL_LAT);

    // reset three cycles into a div
    step(1, 0, 4'd4, 4'd9, 32'd100, 32'd7);
    step(0, 0, 4'd0, 4'd9, 0, 0);
    step(0, 0, 4'd0, 4'd9, 0, 0);
    step(0, 0, 4'd0, 4'd9, 0, 0);
    chk("pre_reset_stall", bus.stall_d, 1'b1);
    do_reset();
    step(0, 0, 4'd0, 4'd9, 0, 0);
    chk("post_reset_stall", bus.stall_d, 1'b0);

    // Busy dropped early during a mult
    step(1, 0, 4'd1, 4'd0, 32'd2, 32'd2);
    step(0, 0, 0, 0, 0, 0);
    force_low = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    force_low = 1'b0;
    chk("err_not_yet", bus.md_err, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    chk("err_set", bus.md_err, 1'b1);
    idle(8);
    chk("err_sticky", bus.md_err, 1'b1);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("err_after_reset", bus.md_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
